// File: rtl/cpu_clock_gen.sv
// cpu_clock_gen: slow CPU clock T from fabric clock U with clamped half-periods, free-run, single-step and clean halt (optional CYCCNT under CPU_CLOCK_GEN_CYCCNT_EN)
module cpu_clock_gen #(
    parameter int CNTW  = 16,
    parameter int MINLO = 2,
    parameter int MINHI = 441
) (
    input  logic            U,
    input  logic            RESET,
    input  logic            RUN,
    input  logic            STEP,
    output logic            STEPACK,
    input  logic [CNTW-1:0] DIVLO,
    input  logic [CNTW-1:0] DIVHI,
    output logic            T,
    output logic            BUSY
`ifdef CPU_CLOCK_GEN_CYCCNT_EN
   ,output logic [31:0]     CYCCNT
`endif
);
    localparam logic [1:0]      IDLE    = 2'd0;
    localparam logic [1:0]      LOW_RUN = 2'd1;
    localparam logic [1:0]      HIGH    = 2'd2;
    localparam logic [CNTW-1:0] MIN_LO  = CNTW'(MINLO);
    localparam logic [CNTW-1:0] MIN_HI  = CNTW'(MINHI);
    localparam logic [CNTW-1:0] ONE     = CNTW'(1);

    logic [1:0]      state, state_n;
    logic [CNTW-1:0] cnt, cnt_n, lo, hi;
    logic            stepping, stepping_n, done;

    assign lo   = (DIVLO < MIN_LO) ? MIN_LO : DIVLO;
    assign hi   = (DIVHI < MIN_HI) ? MIN_HI : DIVHI;
    assign done = (state == HIGH) && (cnt == '0);

    // next state: phases only end when their counter expires; RUN/STEP are looked at only in IDLE and at end of HIGH
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        stepping_n = stepping;
        case (state)
            IDLE: begin
                if (RUN || STEP) begin
                    state_n    = LOW_RUN;
                    cnt_n      = lo - ONE;
                    stepping_n = !RUN;
                end
            end
            LOW_RUN: begin
                state_n = (cnt == '0) ? HIGH : LOW_RUN;
                cnt_n   = (cnt == '0) ? hi - ONE : cnt - ONE;
            end
            HIGH: begin
                cnt_n = cnt - ONE;
                if (cnt == '0) begin
                    stepping_n = 1'b0;
                    state_n    = (!stepping && RUN) ? LOW_RUN : IDLE;
                    cnt_n      = (!stepping && RUN) ? lo - ONE : '0;
                end
            end
            default: begin
                state_n    = IDLE;
                cnt_n      = '0;
                stepping_n = 1'b0;
            end
        endcase
    end

    // state, counter and glitch-free registered outputs; reset stops T abruptly
    always_ff @(posedge U) begin
        if (RESET) begin
            state    <= IDLE;
            cnt      <= '0;
            stepping <= 1'b0;
            T        <= 1'b0;
            BUSY     <= 1'b0;
            STEPACK  <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            stepping <= stepping_n;
            T        <= (state_n == HIGH);
            BUSY     <= (state_n == LOW_RUN) || (state_n == HIGH);
            STEPACK  <= done && stepping;
        end
    end

`ifdef CPU_CLOCK_GEN_CYCCNT_EN
    // completed CPU cycles, counted on every falling edge of T
    always_ff @(posedge U) begin
        if (RESET) CYCCNT <= '0;
        else       CYCCNT <= done ? CYCCNT + 32'd1 : CYCCNT;
    end
`endif

endmodule

// File: tb/tb_cpu_clock_gen.sv
// tb_cpu_clock_gen: directed vector bench for cpu_clock_gen
module tb_cpu_clock_gen;
    logic        u = 1'b0;
    logic        reset, run, step;
    logic [15:0] divlo, divhi;
    logic        stepack, t, busy;
`ifdef CPU_CLOCK_GEN_CYCCNT_EN
    logic [31:0] cyccnt;
`endif
    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        int divlo;
        int divhi;
        int exp_lo;
        int exp_hi;
    } vec_t;

    cpu_clock_gen dut (
        .U(u),
        .RESET(reset),
        .RUN(run),
        .STEP(step),
        .STEPACK(stepack),
        .DIVLO(divlo),
        .DIVHI(divhi),
        .T(t),
        .BUSY(busy)
`ifdef CPU_CLOCK_GEN_CYCCNT_EN
       ,.CYCCNT(cyccnt)
`endif
    );

    always #5 u = ~u;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        run   = 1'b0;
        step  = 1'b0;
        reset = 1'b1;
        @(negedge u);
        @(negedge u);
        reset = 1'b0;
    endtask

    task automatic wait_busy(input string name);
        int n = 0;
        while (!busy && n < 20) begin
            @(negedge u);
            n++;
        end
        check(name, int'(busy), 1);
    endtask

    task automatic measure(input logic level, output int n);
        n = 0;
        while (t == level && n < 2000) begin
            n++;
            @(negedge u);
        end
    endtask

    vec_t vecs[5];

    initial begin
        int l1, h1, l2, h2, l3, h3, a, b, bad, busy_n, rises, acks, ack_fall;
        logic pt;
        vecs[0] = '{10, 500, 10, 500};
        vecs[1] = '{0, 5, 2, 441};
        vecs[2] = '{1, 441, 2, 441};
        vecs[3] = '{3, 442, 3, 442};
        vecs[4] = '{2, 0, 2, 441};
        reset = 1'b1; run = 1'b0; step = 1'b0; divlo = 16'd0; divhi = 16'd0;
        @(negedge u);
        do_reset();
        check("reset_t", int'(t), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_stepack", int'(stepack), 0);
`ifdef CPU_CLOCK_GEN_CYCCNT_EN
        check("reset_cyccnt", int'(cyccnt), 0);
`endif

        for (int i = 0; i < 5; i++) begin
            do_reset();
            divlo = 16'(vecs[i].divlo);
            divhi = 16'(vecs[i].divhi);
            run   = 1'b1;
            wait_busy($sformatf("v%0d_start", i));
            measure(1'b0, l1); measure(1'b1, h1);
            measure(1'b0, l2); measure(1'b1, h2);
            measure(1'b0, l3); measure(1'b1, h3);
            check($sformatf("v%0d_lo", i), l1, vecs[i].exp_lo);
            check($sformatf("v%0d_hi", i), h1, vecs[i].exp_hi);
            check($sformatf("v%0d_period", i), l2 + h2, vecs[i].exp_lo + vecs[i].exp_hi);
            check($sformatf("v%0d_hi3", i), h3, vecs[i].exp_hi);
`ifdef CPU_CLOCK_GEN_CYCCNT_EN
            check($sformatf("v%0d_cyccnt", i), int'(cyccnt), 3);
`endif
        end

        // single step while halted
        do_reset();
        divlo = 16'd4; divhi = 16'd600;
        step = 1'b1;
        busy_n = 0; rises = 0; acks = 0; ack_fall = 0; pt = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge u);
            step = 1'b0;
            busy_n += int'(busy);
            rises += int'(t && !pt);
            acks += int'(stepack);
            ack_fall += int'(stepack && pt && !t);
            pt = t;
        end
        check("step_busy_cycles", busy_n, 604);
        check("step_rises", rises, 1);
        check("step_acks", acks, 1);
        check("step_ack_on_fall", ack_fall, 1);
        check("step_idle", int'(busy), 0);

        // halt mid-HIGH finishes the phase
        do_reset();
        divlo = 16'd4; divhi = 16'd600; run = 1'b1;
        wait_busy("halt_start");
        measure(1'b0, l1);
        a = 0;
        while (t && a < 100) begin
            a++;
            @(negedge u);
        end
        run = 1'b0;
        measure(1'b1, b);
        check("halt_lo", l1, 4);
        check("halt_hi_full", a + b, 600);
        bad = 0;
        for (int i = 0; i < 700; i++) begin
            bad += int'(t || busy);
            @(negedge u);
        end
        check("halt_stays_idle", bad, 0);

        // DIVHI change mid-HIGH applies to the next HIGH only
        do_reset();
        divlo = 16'd10; divhi = 16'd500; run = 1'b1;
        wait_busy("div_start");
        measure(1'b0, l1);
        a = 0;
        while (t && a < 50) begin
            a++;
            @(negedge u);
        end
        divhi = 16'd800;
        measure(1'b1, b);
        measure(1'b0, l2);
        measure(1'b1, h2);
        check("div_cur_hi", a + b, 500);
        check("div_next_lo", l2, 10);
        check("div_next_hi", h2, 800);

        // reset mid-HIGH drops T on the next edge, then restart from IDLE
        do_reset();
        divlo = 16'd4; divhi = 16'd600; run = 1'b1;
        wait_busy("rst_start");
        measure(1'b0, l1);
        for (int i = 0; i < 50; i++) @(negedge u);
        check("rst_pre_t", int'(t), 1);
        reset = 1'b1;
        @(negedge u);
        reset = 1'b0;
        check("rst_t", int'(t), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_stepack", int'(stepack), 0);
`ifdef CPU_CLOCK_GEN_CYCCNT_EN
        check("rst_cyccnt", int'(cyccnt), 0);
`endif
        @(negedge u);
        check("rst_restart_busy", int'(busy), 1);
        measure(1'b0, l1);
        check("rst_restart_lo", l1, 4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
